// File: rtl/bp_be_fe_queue_ckpt_if.sv
// FE-to-scheduler queue bundle: FE enqueue handshake plus the scheduler's
// issue handshake and clear/roll/dequeue controls.
interface bp_be_fe_queue_ckpt_if #(
  parameter int entry_width_p = 128
);
  logic [entry_width_p-1:0] fe_queue_i;
  logic                     fe_queue_v_i;
  logic                     fe_queue_ready_o;
  logic [entry_width_p-1:0] fe_queue_o;
  logic                     fe_queue_v_o;
  logic                     fe_queue_yumi_i;
  logic                     fe_queue_clr_i;
  logic                     fe_queue_roll_i;
  logic                     fe_queue_deq_i;

  modport master (
    output fe_queue_i, fe_queue_v_i, fe_queue_yumi_i,
           fe_queue_clr_i, fe_queue_roll_i, fe_queue_deq_i,
    input  fe_queue_ready_o, fe_queue_o, fe_queue_v_o
  );

  modport slave (
    input  fe_queue_i, fe_queue_v_i, fe_queue_yumi_i,
           fe_queue_clr_i, fe_queue_roll_i, fe_queue_deq_i,
    output fe_queue_ready_o, fe_queue_o, fe_queue_v_o
  );
endinterface

// File: rtl/bp_be_fe_queue_ckpt.sv
// Checkpointed FE queue: speculative issue, release on commit, roll and clear.
// Define BP_BE_FE_QUEUE_HWM_EN to build the occupancy high-watermark register.
module bp_be_fe_queue_ckpt #(
  parameter  int els_p         = 8,
  parameter  int entry_width_p = 128,
  localparam int ptr_width_lp  = $clog2(els_p) + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  bp_be_fe_queue_ckpt_if.slave    fe_if,
  output logic [ptr_width_lp-1:0] hwm_o
);
  localparam int lg_els_lp = $clog2(els_p);

  logic [entry_width_p-1:0] mem_q [els_p];
  logic [ptr_width_lp-1:0]  wptr_q, wptr_d;
  logic [ptr_width_lp-1:0]  rptr_q, rptr_d;
  logic [ptr_width_lp-1:0]  cptr_q, cptr_d;
  logic [ptr_width_lp-1:0]  rptr_y;
  logic                     full, valid, enq, yumi_ok;

  // Full when the write pointer is exactly one lap ahead of the checkpoint.
  assign full    = (wptr_q[lg_els_lp-1:0] == cptr_q[lg_els_lp-1:0])
                && (wptr_q[lg_els_lp] != cptr_q[lg_els_lp]);
  assign valid   = (rptr_q != wptr_q);
  assign enq     = fe_if.fe_queue_v_i & ~full & ~fe_if.fe_queue_clr_i;
  assign yumi_ok = fe_if.fe_queue_yumi_i & valid;

  assign fe_if.fe_queue_ready_o = ~full;
  assign fe_if.fe_queue_v_o     = valid;
  assign fe_if.fe_queue_o       = mem_q[rptr_q[lg_els_lp-1:0]];

  always_comb begin
    rptr_y = rptr_q + ptr_width_lp'(yumi_ok);
    rptr_d = rptr_y;
    cptr_d = cptr_q;
    wptr_d = wptr_q + ptr_width_lp'(enq);
    if (fe_if.fe_queue_roll_i) begin
      rptr_d = cptr_q;
    end else if (fe_if.fe_queue_deq_i) begin
      cptr_d = rptr_y;
    end
    if (fe_if.fe_queue_clr_i) begin
      wptr_d = rptr_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wptr_q[lg_els_lp-1:0]] <= fe_if.fe_queue_i;
    end
  end

`ifdef BP_BE_FE_QUEUE_HWM_EN
  logic [ptr_width_lp-1:0] hwm_q, hwm_d, occ_d;

  assign occ_d = wptr_d - cptr_d;
  assign hwm_d = (occ_d > hwm_q) ? occ_d : hwm_q;
  assign hwm_o = hwm_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end
`else
  assign hwm_o = '0;
`endif

  a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
    !(fe_if.fe_queue_yumi_i && !valid));

endmodule

// File: doc/bp_be_fe_queue_ckpt.md
# bp_be_fe_queue_ckpt

Checkpointed FIFO between the front-end fetch stage and the back-end checker's scheduler. It holds PC/instruction packets produced by the FE and issues them speculatively to the scheduler. Storage for an entry is released only when the checker commits it. Any issued-but-uncommitted packets can be replayed with a roll, and any unread packets can be discarded with a clear, which supports the scheduler's `fe_queue_clr_o` / `fe_queue_roll_o` / `fe_queue_deq_o` controls.

## Interface
- `els_p`, 8: queue depth in entries; power of two, ≥2.
- `entry_width_p`, 128: width of one FE queue packet.
- `ptr_width_lp`, `$clog2(els_p)+1`: pointer width, with the extra MSB used as the wrap bit (localparam).

- `clk_i`  in  1  clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `fe_queue_i`  in  `entry_width_p`  packet from FE.
- `fe_queue_v_i`  in  1  FE packet valid.
- `fe_queue_ready_o`  out  1  space available; enqueue occurs on `v_i & ready_o`.
- `fe_queue_o`  out  `entry_width_p`  packet at the speculative read pointer.
- `fe_queue_v_o`  out  1  an unread packet is present.
- `fe_queue_yumi_i`  in  1  scheduler consumes the packet; legal only when `v_o`=1.
- `fe_queue_clr_i`  in  1  discard all unread packets.
- `fe_queue_roll_i`  in  1  rewind the read pointer to the checkpoint.
- `fe_queue_deq_i`  in  1  commit all read packets by moving the checkpoint to the read pointer.
- `hwm_o`  out  `ptr_width_lp`  occupancy high-watermark (see Configuration).

## Operation
- Three pointers, each `ptr_width_lp` bits and wrapping modulo `2*els_p`:
  - `wptr`: write pointer.
  - `rptr`: speculative read pointer.
  - `cptr`: committed checkpoint.
- Invariant: `cptr ≤ rptr ≤ wptr`, measured in circular distance.
- Occupancy is `wptr - cptr`.
  - `full` when occupancy equals `els_p`, i.e. low bits equal and wrap bits differ.
  - `ready_o = ~full`.
- `v_o = (rptr != wptr)`. `fe_queue_o = mem[rptr[low]]`, read combinationally; no write-to-read bypass.
- Each cycle, compute the next-state pointers in this order:
  1. `rptr_y = rptr + (yumi_i & v_o)`.
  2. If `roll_i`: `rptr_n = cptr`, and `deq_i` is ignored. Otherwise `rptr_n = rptr_y`, and if `deq_i` then `cptr_n = rptr_y`.
  3. If `clr_i`: `wptr_n = rptr_n`, and enqueue is suppressed that cycle. Otherwise `wptr_n = wptr + (v_i & ready_o)`, with the memory write at `wptr[low]`.
- `roll_i` and `clr_i` together: `rptr` and `wptr` both collapse to `cptr`, giving an empty, fully committed queue.
- `ready_o` depends only on registered state; it does not reflect a same-cycle `deq_i`.
- `yumi_i` asserted while `v_o`=0 is an illegal input. It is ignored, and the assertion fires in simulation.

## Timing
- Reset (asynchronous, active-high): all pointers = 0, `v_o`=0, `ready_o`=1, `hwm_o`=0. Memory contents are undefined and never observable.
- Reset asserted mid-operation immediately empties the queue. An enqueue in flight on that edge is lost.
- Enqueue-to-visible latency: 1 cycle. A packet accepted at edge N appears on `fe_queue_o` with `v_o`=1 after edge N.
- Space freed by `deq_i` at edge N is visible on `ready_o` after edge N.
- Roll and clear take effect at the next edge. `fe_queue_o` shows the rolled entry in the following cycle.
- Full and empty wrap correctly through `2*els_p` pointer values. Simultaneous enqueue and yumi when occupancy is `els_p-1` is legal.

## Configuration
- `BP_BE_FE_QUEUE_HWM_EN` defined: a register tracks the maximum of `wptr_n - cptr_n` since reset and drives `hwm_o`.
- Undefined: `hwm_o` is tied to 0 and the register is not built.
- Queue behaviour is otherwise identical in both cases.

## Test plan
- Fill and drain, `els_p`=8: enqueue 8 packets → `ready_o`=0 after the 8th edge. Yumi and deq all 8 → `ready_o`=1 and `v_o`=0, and the data order matches the enqueue order.
- Roll replay: enqueue A, B, C; yumi A and B with no deq; roll → `fe_queue_o`=A next cycle, and yumi A, B, C returns the same values.
- Clear: enqueue 5 packets, yumi 2, deq, clr → `v_o`=0 and occupancy 0. A new packet D enqueued afterwards is the next packet issued.
- Simultaneous roll+deq+clr with `cptr`=2, `rptr`=4, `wptr`=6 → all pointers = 2 and `ready_o`=1.
- Wrap: run 20 enqueue/yumi/deq cycles at occupancy 7 → no data corruption, and `full` is correct at wrap-bit mismatch.
- Async reset mid-burst (occupancy 5) → `v_o`=0, `ready_o`=1, and `hwm_o`=0 immediately, without waiting for a clock edge. With the macro defined, `hwm_o` was 5 before the reset.
